// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared constants and types for the performance-counter CSR block
package perf_pkg;

    localparam int CSR_DW = 32;

    localparam logic [2:0] ADDR_CTRL       = 3'd0;
    localparam logic [2:0] ADDR_STATUS     = 3'd1;
    localparam logic [2:0] ADDR_TOTAL      = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE     = 3'd3;
    localparam logic [2:0] ADDR_IDLE       = 3'd4;
    localparam logic [2:0] ADDR_RUNS       = 3'd5;
    localparam logic [2:0] ADDR_ACC_ACTIVE = 3'd6;
    localparam logic [2:0] ADDR_RSVD       = 3'd7;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_ACC_CLR = 1;
    localparam int STAT_VALID   = 0;
    localparam int STAT_OVERRUN = 1;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_t;

endpackage

// File: rtl/perf_csr.sv
// rtl/perf_csr.sv - CSR front-end capturing performance-monitor results with run accumulation
module perf_csr
    import perf_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int RUNS_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     meas_done,
    input  logic [COUNTER_WIDTH-1:0] total_in,
    input  logic [COUNTER_WIDTH-1:0] active_in,
    input  logic [COUNTER_WIDTH-1:0] idle_in,
    input  logic                     csr_req,
    input  logic                     csr_we,
    input  logic [2:0]               csr_addr,
    input  logic [31:0]              csr_wdata,
    output logic                     csr_ack,
    output logic [31:0]              csr_rdata,
    output logic                     csr_err,
    output logic                     irq
);

    bus_state_t state_q, state_d;

    logic                  irq_en_q;
    logic                  valid_q;
    logic                  overrun_q;
    logic [CSR_DW-1:0]     total_q;
    logic [CSR_DW-1:0]     active_q;
    logic [CSR_DW-1:0]     idle_q;
    logic [RUNS_WIDTH-1:0] runs_q;
    logic [CSR_DW-1:0]     acc_q;
    logic [CSR_DW-1:0]     rdata_q;
    logic                  err_q;

    logic                  sample;
    logic                  addr_err;
    logic                  wr_ctrl;
    logic                  wr_stat;
    logic                  acc_clr;
    logic                  w1c_valid;
    logic                  w1c_overrun;
    logic [CSR_DW-1:0]     rd_mux;
    logic [CSR_DW-1:0]     acc_base;
    logic [CSR_DW:0]       acc_sum;
    logic [CSR_DW-1:0]     acc_d;
    logic [RUNS_WIDTH-1:0] runs_base;
    logic [RUNS_WIDTH-1:0] runs_d;
    logic                  wdata_unused;

    assign wdata_unused = ^csr_wdata[31:2];

    // A request is only taken in IDLE; the ack cycle ignores csr_req.
    assign sample = (state_q == BUS_IDLE) && csr_req;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (csr_req) state_d = BUS_RESP;
            BUS_RESP: state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    assign addr_err = (csr_addr == ADDR_RSVD) ||
                      (csr_we && (csr_addr != ADDR_CTRL) && (csr_addr != ADDR_STATUS));

    assign wr_ctrl     = sample && csr_we && (csr_addr == ADDR_CTRL);
    assign wr_stat     = sample && csr_we && (csr_addr == ADDR_STATUS);
    assign acc_clr     = wr_ctrl && csr_wdata[CTRL_ACC_CLR];
    assign w1c_valid   = wr_stat && csr_wdata[STAT_VALID];
    assign w1c_overrun = wr_stat && csr_wdata[STAT_OVERRUN];

    always_comb begin
        rd_mux = '0;
        case (csr_addr)
            ADDR_CTRL:       rd_mux[CTRL_IRQ_EN] = irq_en_q;
            ADDR_STATUS: begin
                rd_mux[STAT_VALID]   = valid_q;
                rd_mux[STAT_OVERRUN] = overrun_q;
            end
            ADDR_TOTAL:      rd_mux = total_q;
            ADDR_ACTIVE:     rd_mux = active_q;
            ADDR_IDLE:       rd_mux = idle_q;
            ADDR_RUNS:       rd_mux = CSR_DW'(runs_q);
            ADDR_ACC_ACTIVE: rd_mux = acc_q;
            default:         rd_mux = '0;
        endcase
    end

    // Clear is applied first so a coincident result starts a fresh run.
    always_comb begin
        acc_base  = acc_clr ? '0 : acc_q;
        acc_sum   = {1'b0, acc_base} + {1'b0, CSR_DW'(active_in)};
        acc_d     = acc_base;
        runs_base = acc_clr ? '0 : runs_q;
        runs_d    = runs_base;
        if (meas_done) begin
            acc_d  = acc_sum[CSR_DW] ? '1 : acc_sum[CSR_DW-1:0];
            runs_d = (&runs_base) ? runs_base : runs_base + RUNS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BUS_IDLE;
            irq_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            total_q   <= '0;
            active_q  <= '0;
            idle_q    <= '0;
            runs_q    <= '0;
            acc_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            irq       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sample) begin
                rdata_q <= (csr_we || addr_err) ? '0 : rd_mux;
                err_q   <= addr_err;
            end
            if (wr_ctrl) irq_en_q <= csr_wdata[CTRL_IRQ_EN];
            // Result arrival takes priority over a coincident write-1-to-clear.
            valid_q   <= meas_done ? 1'b1 : (w1c_valid ? 1'b0 : valid_q);
            overrun_q <= (meas_done && valid_q) ? 1'b1 : (w1c_overrun ? 1'b0 : overrun_q);
            if (meas_done) begin
                total_q  <= CSR_DW'(total_in);
                active_q <= CSR_DW'(active_in);
                idle_q   <= CSR_DW'(idle_in);
            end
            runs_q <= runs_d;
            acc_q  <= acc_d;
            irq    <= irq_en_q & valid_q;
        end
    end

    assign csr_ack   = (state_q == BUS_RESP);
    assign csr_rdata = csr_ack ? rdata_q : '0;
    assign csr_err   = csr_ack && err_q;

endmodule

// File: tb/tb_perf_csr.sv
// tb/tb_perf_csr.sv - randomized and directed self-checking bench for perf_csr
module tb_perf_csr;

    localparam int CW = 32;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          meas_done;
    logic [CW-1:0] total_in, active_in, idle_in;
    logic          csr_req, csr_we;
    logic [2:0]    csr_addr;
    logic [31:0]   csr_wdata;
    logic          csr_ack;
    logic [31:0]   csr_rdata;
    logic          csr_err;
    logic          irq;

    perf_csr #(.COUNTER_WIDTH(CW), .RUNS_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .meas_done(meas_done),
        .total_in(total_in), .active_in(active_in), .idle_in(idle_in),
        .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_ack(csr_ack), .csr_rdata(csr_rdata), .csr_err(csr_err), .irq(irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: register contents as the register map describes them.
    bit          m_en, m_val, m_ovr;
    logic [31:0] m_tot, m_act, m_idl;
    longint      m_runs, m_acc;
    bit          m_ack, m_err, m_irq;
    logic [31:0] m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_view(input logic [2:0] a);
        case (a)
            3'd0:    return {31'b0, m_en};
            3'd1:    return {30'b0, m_ovr, m_val};
            3'd2:    return m_tot;
            3'd3:    return m_act;
            3'd4:    return m_idl;
            3'd5:    return m_runs[31:0];
            3'd6:    return m_acc[31:0];
            default: return 32'h0;
        endcase
    endfunction

    // Advance the reference by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit          take, bad, old_val, new_irq;
        logic [31:0] rd;
        if (!rst_n) begin
            m_en = 0; m_val = 0; m_ovr = 0;
            m_tot = 0; m_act = 0; m_idl = 0; m_runs = 0; m_acc = 0;
            m_ack = 0; m_err = 0; m_irq = 0; m_rdata = 0;
            return;
        end
        take    = csr_req && !m_ack;
        bad     = (csr_addr == 3'd7) || (csr_we && csr_addr >= 3'd2);
        rd      = reg_view(csr_addr);
        new_irq = m_en & m_val;
        old_val = m_val;
        if (take && csr_we && !bad) begin
            if (csr_addr == 3'd0) begin
                m_en = csr_wdata[0];
                if (csr_wdata[1]) begin
                    m_runs = 0;
                    m_acc  = 0;
                end
            end else begin
                if (csr_wdata[0]) m_val = 0;
                if (csr_wdata[1]) m_ovr = 0;
            end
        end
        if (meas_done) begin
            if (old_val) m_ovr = 1;
            m_val  = 1;
            m_tot  = 32'(total_in);
            m_act  = 32'(active_in);
            m_idl  = 32'(idle_in);
            m_runs = (m_runs == (longint'(1) << RW) - 1) ? m_runs : m_runs + 1;
            m_acc  = m_acc + longint'(active_in);
            if (m_acc > 64'hFFFF_FFFF) m_acc = 64'hFFFF_FFFF;
        end
        m_ack   = take;
        m_err   = take && bad;
        m_rdata = (take && !csr_we && !bad) ? rd : 32'h0;
        m_irq   = new_irq;
    endtask

    task automatic compare_all();
        check("ack", csr_ack, m_ack);
        check("rdata", csr_rdata, m_rdata);
        check("err", csr_err, m_err);
        check("irq", irq, m_irq);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic bus(input bit we, input logic [2:0] a, input logic [31:0] wd,
                       input bit meas, input logic [31:0] t, input logic [31:0] ac,
                       input logic [31:0] id, output logic [31:0] rd, output bit er);
        csr_req = 1; csr_we = we; csr_addr = a; csr_wdata = wd;
        meas_done = meas; total_in = t; active_in = ac; idle_in = id;
        cycle();
        check("ack_latency", csr_ack, 1);
        rd = csr_rdata;
        er = csr_err;
        csr_req = 0; meas_done = 0;
        cycle();
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        bit          er;
        bus(1, a, wd, 0, 0, 0, 0, rd, er);
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] rd);
        bit er;
        bus(0, a, 0, 0, 0, 0, 0, rd, er);
    endtask

    task automatic meas(input logic [31:0] t, input logic [31:0] ac, input logic [31:0] id);
        meas_done = 1; total_in = t; active_in = ac; idle_in = id;
        cycle();
        meas_done = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          er;
        rst_n = 0; meas_done = 0; total_in = 0; active_in = 0; idle_in = 0;
        csr_req = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
        repeat (3) cycle();
        check("reset_ack", csr_ack, 0);
        check("reset_irq", irq, 0);
        rst_n = 1;
        cycle();

        meas(100, 70, 30);
        csr_read(3'd2, rd); check("total_100", rd, 100);
        csr_read(3'd3, rd); check("active_70", rd, 70);
        csr_read(3'd4, rd); check("idle_30", rd, 30);
        csr_read(3'd1, rd); check("status_valid", rd, 32'h1);

        csr_write(3'd0, 32'h1);
        check("irq_set", irq, 1);
        meas(5, 4, 1);
        csr_read(3'd1, rd); check("status_overrun", rd, 32'h3);
        csr_req = 1; csr_we = 1; csr_addr = 3'd1; csr_wdata = 32'h3;
        cycle();
        check("irq_hold_ack_cycle", irq, 1);
        csr_req = 0;
        cycle();
        check("irq_fall", irq, 0);
        csr_read(3'd1, rd); check("status_cleared", rd, 32'h0);

        csr_write(3'd0, 32'h3);
        csr_read(3'd5, rd); check("runs_cleared", rd, 0);
        csr_read(3'd6, rd); check("acc_cleared", rd, 0);
        meas(1, 32'hFFFF_FFF0, 2);
        csr_read(3'd6, rd); check("acc_fff0", rd, 32'hFFFF_FFF0);
        meas(1, 32'h20, 3);
        csr_read(3'd6, rd); check("acc_saturate", rd, 32'hFFFF_FFFF);
        csr_read(3'd5, rd); check("runs_two", rd, 2);
        csr_read(3'd0, rd); check("ctrl_clr_reads_0", rd, 32'h1);

        csr_write(3'd1, 32'h3);
        meas(7, 7, 7);
        bus(1, 3'd1, 32'h1, 1, 9, 8, 1, rd, er);
        csr_read(3'd1, rd); check("w1c_vs_set", rd, 32'h3);

        bus(1, 3'd2, 32'hDEAD, 0, 0, 0, 0, rd, er);
        check("ro_write_err", er, 1); check("ro_write_rdata", rd, 0);
        bus(0, 3'd7, 0, 0, 0, 0, 0, rd, er);
        check("rsvd_err", er, 1); check("rsvd_rdata", rd, 0);
        bus(0, 3'd2, 0, 0, 0, 0, 0, rd, er);
        check("total_unchanged", rd, 9); check("total_no_err", er, 0);

        bus(1, 3'd0, 32'h2, 1, 11, 5, 6, rd, er);
        csr_read(3'd5, rd); check("clr_meas_runs", rd, 1);
        csr_read(3'd6, rd); check("clr_meas_acc", rd, 5);

        for (int i = 0; i < 3000; i++) begin
            if (csr_req && m_ack) begin
                csr_req = 0;
            end else if (!csr_req && ($urandom_range(0, 1) == 1)) begin
                csr_req   = 1;
                csr_we    = $urandom_range(0, 1) == 1;
                csr_addr  = 3'($urandom_range(0, 7));
                csr_wdata = $urandom;
                if (csr_addr == 3'd0) csr_wdata[1] = ($urandom_range(0, 7) == 0);
            end
            meas_done = ($urandom_range(0, 3) == 0);
            total_in  = $urandom;
            active_in = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
            idle_in   = $urandom;
            cycle();
        end
        csr_req = 0; meas_done = 0;
        cycle();

        csr_write(3'd0, 32'h1);
        meas(3, 2, 1);
        cycle();
        check("pre_reset_irq", irq, 1);
        csr_req = 1; csr_we = 0; csr_addr = 3'd2;
        cycle();
        check("in_resp", csr_ack, 1);
        rst_n = 0;
        #1;
        check("rst_mid_ack", csr_ack, 0);
        check("rst_mid_irq", irq, 0);
        check("rst_mid_rdata", csr_rdata, 0);
        csr_req = 0;
        @(negedge clk);
        cycle();
        rst_n = 1;
        cycle();
        for (int a = 0; a < 7; a++) begin
            csr_read(3'(a), rd);
            check($sformatf("post_reset_reg%0d", a), rd, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/perf_csr.md
PERF_CSR -- requirements
Module: perf_csr

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, the width of the monitor count inputs; legal range 1..32.
REQ-002 SHALL have parameter RUNS_WIDTH, default 16, the width of the completed-run counter.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port meas_done  input  1  single-cycle result-ready pulse from the performance monitor.
REQ-006 SHALL have ports total_in, active_in, idle_in  input  COUNTER_WIDTH each  final counts, valid while meas_done=1.
REQ-007 SHALL have port csr_req  input  1  bus request, held high until csr_ack.
REQ-008 SHALL have port csr_we  input  1  1=write, 0=read; stable while csr_req=1.
REQ-009 SHALL have port csr_addr  input  3  word address; stable while csr_req=1.
REQ-010 SHALL have port csr_wdata  input  32  write data; stable while csr_req=1.
REQ-011 SHALL have port csr_ack  output  1  single-cycle completion pulse.
REQ-012 SHALL have port csr_rdata  output  32  read data, valid only while csr_ack=1, zero otherwise.
REQ-013 SHALL have port csr_err  output  1  error flag, valid only while csr_ack=1.
REQ-014 SHALL have port irq  output  1  level interrupt, registered.

Function
REQ-015 SHALL implement this register map: 0 CTRL RW (bit0 irq_en, bit1 acc_clr self-clearing); 1 STATUS (bit0 valid, bit1 overrun; write-1-to-clear); 2 TOTAL RO; 3 ACTIVE RO; 4 IDLE RO; 5 RUNS RO; 6 ACC_ACTIVE RO; 7 reserved.
REQ-016 SHALL, on meas_done=1, latch total_in, active_in and idle_in into TOTAL, ACTIVE and IDLE in the same edge, zero-extended to 32 bits.
REQ-017 SHALL, on meas_done=1, set STATUS.valid; if valid was already 1, it SHALL also set STATUS.overrun.
REQ-018 SHALL, on meas_done=1, increment RUNS, saturating at all-ones.
REQ-019 SHALL, on meas_done=1, add active_in to the 32-bit ACC_ACTIVE register, saturating at 0xFFFFFFFF with no wrap.
REQ-020 SHALL use a two-state bus FSM: IDLE -> RESP when csr_req=1; RESP drives csr_ack=1 for exactly one cycle, then returns to IDLE.
REQ-021 SHALL give a fixed latency of 1 cycle from req-sample to ack, and SHALL take no back-to-back request in the ack cycle (minimum 2-cycle spacing).
REQ-022 SHALL return read data for the register value at the req-sample edge; a meas_done on that same edge SHALL update the register but not the returned data.
REQ-023 SHALL apply STATUS write-1-to-clear bits at the req-sample edge; if meas_done arrives on the same edge, set SHALL win over clear.
REQ-024 SHALL, on a CTRL write with bit1=1, zero ACC_ACTIVE and RUNS; a meas_done on the same edge SHALL load the new run only (RUNS=1, ACC_ACTIVE=active_in).
REQ-025 SHALL always read CTRL.bit1 as 0.
REQ-026 SHALL treat a write to a RO address or any access to address 7 as an error: csr_err=1, csr_rdata=0, no state change; the ack is still given.
REQ-027 SHALL register irq as CTRL.irq_en AND STATUS.valid, one cycle after either operand changes.

Reset
REQ-028 SHALL, on reset, clear all registers, the FSM (to IDLE), csr_ack, csr_err, csr_rdata and irq to 0, asynchronously.
REQ-029 SHALL, on reset mid-transaction, abandon the transaction with no ack; the master re-issues it.

Structure
REQ-030 SHALL define address localparams, STATUS/CTRL bit indices and the CSR data width of 32 in shared package perf_pkg.
REQ-031 SHALL be a single module with no sub-module; the saturating adder is inline.

Verification
REQ-032 SHALL cover: meas_done with total=100, active=70, idle=30, then read addrs 2/3/4/1 -> 100, 70, 30, 0x1; each ack 1 cycle after req.
REQ-033 SHALL cover: two meas_done pulses without a clear -> STATUS=0x3; write 0x3 to STATUS -> reads 0x0; irq falls one cycle later with irq_en=1.
REQ-034 SHALL cover: ACC_ACTIVE at 0xFFFFFFF0 plus meas_done with active=0x20 -> ACC_ACTIVE=0xFFFFFFFF.
REQ-035 SHALL cover: STATUS W1C of bit0 on the same edge as meas_done -> valid stays 1.
REQ-036 SHALL cover: write to addr 2, then read addr 7 -> both csr_err=1, csr_rdata=0, TOTAL unchanged.
REQ-037 SHALL cover: rst_n low while in RESP -> csr_ack, irq and all registers equal 0 on the next sample.
